yin_threshold: RTL and testbench
================================

YIN_THRESHOLD -- requirements
Module: yin_threshold

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width; difference values are 2*WIDTH bits.
REQ-002 SHALL have parameter TAUMAX, default 2048: maximum lag count per frame; TW = $clog2(TAUMAX).
REQ-003 SHALL have parameter THRESH_FRAC_BITS, default 8: fractional bits of THRESHOLD.
REQ-004 SHALL have parameter THRESHOLD, default 26 (~0.10, unsigned Q0.8): absolute YIN threshold.
REQ-005 SHALL have parameter TAU_MIN, default 32: lowest eligible lag when YIN_TAU_MIN_EN is defined.
REQ-006 SHALL have port clk_in, input, 1: the single clock.
REQ-007 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port diff_in, input, 2*WIDTH: difference value d(tau), unsigned.
REQ-009 SHALL have port diff_valid_in, input, 1: a d(tau) beat is present; beats arrive in ascending tau starting at 0.
REQ-010 SHALL have port diff_last_in, input, 1: marks the final beat of a frame.
REQ-011 SHALL have port tau_out, output, TW: detected lag.
REQ-012 SHALL have port found_out, output, 1: 1 = pitch detected, 0 = unvoiced.
REQ-013 SHALL have port tau_valid_out, output, 1: one-cycle pulse qualifying tau_out and found_out.

Function
REQ-014 SHALL count accepted beats with an internal tau counter; tau = 0 at frame start, cleared after the last beat.
REQ-015 SHALL skip tau = 0 for both the running sum and detection (d'(0) = 1 by definition).
REQ-016 SHALL, for tau >= 1, set running sum S(tau) = S(tau-1) + d(tau) at width 2*WIDTH+TW, with no overflow possible.
REQ-017 SHALL, without a divider, evaluate "below threshold" as (d(tau)*tau) << THRESH_FRAC_BITS < THRESHOLD * S(tau), with all operands sized so nothing truncates.
REQ-018 SHALL run a 3-stage pipeline: stage 1 multiplies, stage 2 compares, stage 3 updates the FSM.
REQ-019 SHALL have FSM SEARCH, DESCEND, HOLD; after reset the FSM is in SEARCH.
REQ-020 SHALL move SEARCH->DESCEND on the first eligible below-threshold tau, recording min_tau = tau and min_d = d(tau).
REQ-021 SHALL, in DESCEND, update min_tau and min_d when d(tau) < min_d, and resolve when d(tau) >= min_d: pulse found_out = 1, tau_out = min_tau, then go to HOLD.
REQ-022 SHALL, in HOLD, ignore beats until the last beat, then return to SEARCH.
REQ-023 SHALL, on a last beat, emit a result when in SEARCH (found_out = 0, tau_out = 0) or in DESCEND (found_out = 1, tau_out = min_tau; a last beat that lowers min_d is included first), then return to SEARCH.
REQ-024 SHALL pulse tau_valid_out exactly 3 cycles after the resolving beat is accepted, exactly once per frame.
REQ-025 SHALL treat the beat with tau = TAUMAX-1 as last even if diff_last_in is low.
REQ-026 SHALL give no detection when S = 0 (silent frame), because the strict comparison fails.
REQ-027 SHALL accept beats back-to-back every cycle, and the next frame may start the cycle after a last beat.

Reset
REQ-028 SHALL, on rst_in, clear the tau counter, S, min_tau, min_d and all pipeline valids, and set the FSM to SEARCH.
REQ-029 SHALL drive tau_out = 0, found_out = 0 and tau_valid_out = 0 from reset.
REQ-030 SHALL discard a frame interrupted by reset, producing no output for it; the next beat is tau = 0.

Configuration
REQ-031 SHALL, when macro YIN_TAU_MIN_EN is defined, make only tau >= TAU_MIN eligible for SEARCH->DESCEND; lags below TAU_MIN still accumulate into S.
REQ-032 SHALL, when YIN_TAU_MIN_EN is undefined, make every tau >= 1 eligible, and the TAU_MIN parameter has no effect.

Verification
REQ-033 SHALL cover: all d = 1000, 2048 beats -> one pulse, found_out = 0, tau_out = 0, 3 cycles after beat 2047.
REQ-034 SHALL cover: all-zero frame -> found_out = 0, tau_out = 0.
REQ-035 SHALL cover: d = 1000 except d(100) = 0 -> found_out = 1, tau_out = 100, pulse 3 cycles after beat 101; beats 102..2047 produce no further output.
REQ-036 SHALL cover: d = 1000 except d(50..52) = 10, 5, 8 -> tau_out = 51, resolved at beat 52.
REQ-037 SHALL cover: rst_in asserted at beat 60 of a frame, then the frame of REQ-035 -> exactly one pulse, tau_out = 100.
REQ-038 SHALL cover: TAU_MIN = 200, d = 1000 except d(100) = 0 and d(300) = 0 -> tau_out = 300 with YIN_TAU_MIN_EN defined, tau_out = 100 without it.

Source files
------------

// File: rtl/yin_threshold.sv
// YIN absolute-threshold pitch picker: running-sum normalised compare and dip tracking over d(tau) beats.
// Optional build macro YIN_TAU_MIN_EN restricts the first dip search to tau >= TAU_MIN.
module yin_threshold #(
   parameter  int WIDTH            = 16,
   parameter  int TAUMAX           = 2048,
   parameter  int THRESH_FRAC_BITS = 8,
   parameter  int THRESHOLD        = 26,
   parameter  int TAU_MIN          = 32,
   localparam int TW               = $clog2(TAUMAX)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [2*WIDTH-1:0] diff_in,
   input  logic              diff_valid_in,
   input  logic              diff_last_in,
   output logic [TW-1:0]     tau_out,
   output logic              found_out,
   output logic              tau_valid_out
);

   localparam int DW   = 2 * WIDTH;
   localparam int SW   = DW + TW;
   localparam int TH_W = $clog2(THRESHOLD + 2);
   localparam int CW   = DW + TW + THRESH_FRAC_BITS + TH_W;

`ifdef YIN_TAU_MIN_EN
   localparam int ELIG_MIN = (TAU_MIN > 1) ? TAU_MIN : 1;
`else
   // Every nonzero lag is eligible; TAU_MIN is inert in this build.
   localparam int ELIG_MIN = (TAU_MIN >= 0) ? 1 : 1;
`endif

   typedef enum logic [1:0] {
      SEARCH,
      DESCEND,
      HOLD
   } state_t;

   // Beat intake and stage 1 (multiply)
   logic [TW-1:0] tau_cnt;
   logic [SW-1:0] sum_q;
   logic [SW-1:0] sum_next;
   logic [CW-1:0] lhs_c;
   logic [CW-1:0] rhs_c;
   logic          last_beat;
   logic          elig_c;

   logic          s1_valid;
   logic [TW-1:0] s1_tau;
   logic [DW-1:0] s1_d;
   logic          s1_last;
   logic          s1_elig;
   logic [CW-1:0] s1_lhs;
   logic [CW-1:0] s1_rhs;

   logic          s2_valid;
   logic [TW-1:0] s2_tau;
   logic [DW-1:0] s2_d;
   logic          s2_last;
   logic          s2_below;

   state_t        state, state_n;
   logic [TW-1:0] min_tau, min_tau_n;
   logic [DW-1:0] min_d, min_d_n;
   logic          emit;
   logic          emit_found;
   logic [TW-1:0] emit_tau;

   always_comb begin
      last_beat = diff_last_in || (tau_cnt == TW'(TAUMAX - 1));
      // d(0) is excluded from S; tau = 0 also restarts the sum for a new frame.
      sum_next  = (tau_cnt == '0) ? '0 : sum_q + SW'(diff_in);
      lhs_c     = (CW'(diff_in) * CW'(tau_cnt)) << THRESH_FRAC_BITS;
      rhs_c     = CW'(THRESHOLD) * CW'(sum_next);
      elig_c    = (tau_cnt != '0) && (int'(tau_cnt) >= ELIG_MIN);
   end

   // NOTE: sequential state uses non-blocking assignments only; combinational logic lives in always_comb.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tau_cnt  <= '0;
         sum_q    <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= diff_valid_in;
         if (diff_valid_in) begin
            tau_cnt <= last_beat ? '0 : tau_cnt + TW'(1);
            sum_q   <= sum_next;
         end
      end
   end

   // NOTE: pipeline payload registers are not reset; the valid bits alone qualify them.
   always_ff @(posedge clk_in) begin
      if (diff_valid_in) begin
         s1_tau  <= tau_cnt;
         s1_d    <= diff_in;
         s1_last <= last_beat;
         s1_elig <= elig_c;
         s1_lhs  <= lhs_c;
         s1_rhs  <= rhs_c;
      end
   end

   // Stage 2: strict compare, d'(tau) < threshold without dividing
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk_in) begin
      if (s1_valid) begin
         s2_tau   <= s1_tau;
         s2_d     <= s1_d;
         s2_last  <= s1_last;
         s2_below <= s1_elig && (s1_lhs < s1_rhs);
      end
   end

   // Stage 3: dip-tracking FSM
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_n    = state;
      min_tau_n  = min_tau;
      min_d_n    = min_d;
      emit       = 1'b0;
      emit_found = 1'b0;
      emit_tau   = '0;
      if (s2_valid) begin
         unique case (state)
            SEARCH: begin
               if (s2_below) begin
                  state_n   = DESCEND;
                  min_tau_n = s2_tau;
                  min_d_n   = s2_d;
               end
               if (s2_last) begin
                  state_n    = SEARCH;
                  emit       = 1'b1;
                  emit_found = s2_below;
                  emit_tau   = s2_below ? s2_tau : '0;
               end
            end
            DESCEND: begin
               if (s2_d < min_d) begin
                  min_tau_n = s2_tau;
                  min_d_n   = s2_d;
                  if (s2_last) begin
                     state_n    = SEARCH;
                     emit       = 1'b1;
                     emit_found = 1'b1;
                     emit_tau   = s2_tau;
                  end
               end else begin
                  state_n    = s2_last ? SEARCH : HOLD;
                  emit       = 1'b1;
                  emit_found = 1'b1;
                  emit_tau   = min_tau;
               end
            end
            HOLD: begin
               if (s2_last) state_n = SEARCH;
            end
            default: state_n = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= SEARCH;
         min_tau       <= '0;
         min_d         <= '0;
         tau_out       <= '0;
         found_out     <= 1'b0;
         tau_valid_out <= 1'b0;
      end else begin
         state         <= state_n;
         min_tau       <= min_tau_n;
         min_d         <= min_d_n;
         tau_valid_out <= emit;
         if (emit) begin
            tau_out   <= emit_tau;
            found_out <= emit_found;
         end
      end
   end

endmodule

// File: tb/tb_yin_threshold.sv
// Scoreboard bench for yin_threshold: directed frames push expected results; a monitor checks each pulse.
module tb_yin_threshold;

   localparam int WIDTH  = 16;
   localparam int TAUMAX = 2048;
   localparam int TW     = $clog2(TAUMAX);

`ifdef YIN_TAU_MIN_EN
   localparam bit TMIN_ON = 1'b1;
`else
   localparam bit TMIN_ON = 1'b0;
`endif

   logic               clk_in = 1'b0;
   logic               rst_in;
   logic [2*WIDTH-1:0] diff_in;
   logic               diff_valid_in;
   logic               diff_last_in;
   logic [TW-1:0]      tau_out;
   logic               found_out;
   logic               tau_valid_out;

   yin_threshold #(
      .WIDTH(WIDTH), .TAUMAX(TAUMAX), .THRESH_FRAC_BITS(8), .THRESHOLD(26), .TAU_MIN(200)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .diff_in(diff_in), .diff_valid_in(diff_valid_in),
      .diff_last_in(diff_last_in), .tau_out(tau_out), .found_out(found_out),
      .tau_valid_out(tau_valid_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic found;
      int   tau;
      int   cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   bit          mon_en  = 1'b0;
   logic [31:0] dvals[TAUMAX];

   always @(posedge clk_in) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge clk_in) begin
      if (mon_en && tau_valid_out !== 1'b0) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got tau %0d found %0b at cycle %0d, expected none",
                     tau_out, found_out, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("found", 64'(found_out), 64'(e.found));
            check("tau", 64'(tau_out), 64'(e.tau));
            check("latency_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic fill(input int v);
      for (int i = 0; i < TAUMAX; i++) dvals[i] = 32'(v);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk_in);
         diff_valid_in = 1'b0;
         diff_last_in  = 1'b0;
      end
   endtask

   task automatic drive_frame(input int n, input bit use_last, input int gap,
                              input int res_idx, input bit ef, input int et);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         diff_valid_in = 1'b1;
         diff_in       = dvals[i];
         diff_last_in  = use_last && (i == n - 1);
         if (i == res_idx) sb.push_back('{ef, et, cyc + 3});
         for (int g = 0; g < gap; g++) begin
            @(negedge clk_in);
            diff_valid_in = 1'b0;
            diff_last_in  = 1'b0;
         end
      end
   endtask

   initial begin
      rst_in        = 1'b1;
      diff_in       = '0;
      diff_valid_in = 1'b0;
      diff_last_in  = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      check("reset_tau_out", 64'(tau_out), 64'd0);
      check("reset_found_out", 64'(found_out), 64'd0);
      check("reset_tau_valid_out", 64'(tau_valid_out), 64'd0);
      mon_en = 1'b1;

      // Flat d = 1000: unvoiced, reported at the last beat.
      fill(1000);
      drive_frame(2048, 1'b1, 0, 2047, 1'b0, 0);
      // Silent frame back-to-back: S = 0 never passes the strict compare.
      fill(0);
      drive_frame(2048, 1'b1, 0, 2047, 1'b0, 0);
      // Single dip at 100, resolved by beat 101.
      fill(1000);
      dvals[100] = 0;
      drive_frame(2048, 1'b1, 0, TMIN_ON ? 2047 : 101, !TMIN_ON, TMIN_ON ? 0 : 100);
      // Descending dip 10, 5, 8 at 50..52: minimum at 51, resolved at 52.
      fill(1000);
      dvals[50] = 10;
      dvals[51] = 5;
      dvals[52] = 8;
      drive_frame(2048, 1'b1, 0, TMIN_ON ? 2047 : 52, !TMIN_ON, TMIN_ON ? 0 : 51);
      idle(2);

      // Reset mid-frame at beat 60 discards that frame.
      fill(1000);
      drive_frame(60, 1'b0, 0, -1, 1'b0, 0);
      @(negedge clk_in);
      rst_in        = 1'b1;
      diff_valid_in = 1'b1;
      diff_in       = 32'd1000;
      @(negedge clk_in);
      rst_in        = 1'b0;
      diff_valid_in = 1'b0;
      dvals[100] = 0;
      drive_frame(2048, 1'b1, 0, TMIN_ON ? 2047 : 101, !TMIN_ON, TMIN_ON ? 0 : 100);

      // No last flag: tau = TAUMAX-1 closes the frame on its own.
      fill(1000);
      drive_frame(2048, 1'b0, 0, 2047, 1'b0, 0);
      // Short frame with bubbles; last beat lowers min_d while descending.
      fill(1000);
      dvals[8] = 10;
      dvals[9] = 5;
      drive_frame(10, 1'b1, 1, 9, !TMIN_ON, TMIN_ON ? 0 : 9);
      // Two dips: TAU_MIN = 200 skips the first when the minimum-lag build is used.
      fill(1000);
      dvals[100] = 0;
      dvals[300] = 0;
      drive_frame(2048, 1'b1, 0, TMIN_ON ? 301 : 101, 1'b1, TMIN_ON ? 300 : 100);
      idle(1);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk_in);
      idle(5);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
